lpc_frame_writer: RTL and testbench

- Avalon-MM DDR3 write master downstream of LPCenc.
- Captures each encoded frame (A0..A10, voiced, freq_count) on the frame strobe and writes it as 13 consecutive 16-bit words to DDR3, giving software a parameter dump beside the synthesized audio.
- Configured and polled through a small Avalon-MM CSR slave with the same register layout as write_master.

---
 rtl/lpc_pkg.sv | 25 ++
 rtl/lpc_frame_buf.sv | 67 ++++++
 rtl/lpc_frame_writer.sv | 171 +++++++++++++++++
 tb/tb_lpc_frame_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared constants for the LPC frame writer: CSR map, frame geometry and FSM encoding.
// Latency: n/a. Backpressure: n/a.
package lpc_pkg;

    localparam int LPC_NUM_COEF    = 11;
    localparam int LPC_DATA_W      = 16;
    localparam int LPC_ADDR_W      = 16;
    localparam int WORDS_PER_FRAME = LPC_NUM_COEF + 2;

    localparam logic [2:0] CSR_BASE    = 3'd0;
    localparam logic [2:0] CSR_NFRAMES = 3'd1;
    localparam logic [2:0] CSR_STEP    = 3'd2;
    localparam logic [2:0] CSR_START   = 3'd4;
    localparam logic [2:0] CSR_DONE    = 3'd5;
    localparam logic [2:0] CSR_SRST    = 3'd6;
    localparam logic [2:0] CSR_DROP    = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lpc_frame_buf.sv
// Active + shadow frame registers: active feeds the DDR word mux, shadow absorbs one early frame.
// Latency: loads/captures take effect on the next clk; word select is combinational.
// Backpressure: a capture request while the shadow is full (and not being promoted) raises overrun.
module lpc_frame_buf #(
    parameter int NUM_COEF = 11,
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [NUM_COEF*DATA_W-1:0] coefs,
    input  logic                       voiced,
    input  logic [DATA_W-1:0]          freq_count,
    input  logic                       load_in,
    input  logic                       promote,
    input  logic                       capture_req,
    input  logic [IDX_W-1:0]           word_idx,
    output logic [DATA_W-1:0]          word,
    output logic                       shadow_full,
    output logic                       overrun
);

    localparam int WORDS = NUM_COEF + 2;

    logic [DATA_W-1:0] active   [WORDS];
    logic [DATA_W-1:0] shadow   [WORDS];
    logic [DATA_W-1:0] in_words [WORDS];
    logic              capture;

    always_comb begin
        for (int i = 0; i < NUM_COEF; i++) begin
            in_words[i] = coefs[i*DATA_W +: DATA_W];
        end
        in_words[NUM_COEF]     = {{(DATA_W-1){1'b0}}, voiced};
        in_words[NUM_COEF + 1] = freq_count;
    end

    // A promote frees the shadow in the same cycle, so a coincident frame is kept.
    assign capture = capture_req & (~shadow_full | promote);
    assign overrun = capture_req & shadow_full & ~promote;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            shadow_full <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                active[i] <= '0;
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (load_in) begin
                    active[i] <= in_words[i];
                end else if (promote) begin
                    active[i] <= shadow[i];
                end
                if (capture) begin
                    shadow[i] <= in_words[i];
                end
            end
            shadow_full <= capture | (shadow_full & ~promote);
        end
    end

    assign word = (int'(word_idx) < WORDS) ? active[word_idx] : '0;

endmodule

// File: rtl/lpc_frame_writer.sv
// Avalon-MM write master dumping each LPC frame as 13 consecutive DDR words, with a small CSR slave.
// Latency: first word presented the clk after the frame strobe; CSR readdata one clk after read.
// Backpressure: ddr_waitrequest holds address/data; frames arriving while busy use one shadow slot, then drop.
module lpc_frame_writer
    import lpc_pkg::*;
#(
    parameter int NUM_COEF = LPC_NUM_COEF,
    parameter int DATA_W   = LPC_DATA_W,
    parameter int ADDR_W   = LPC_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_COEF*DATA_W-1:0] coefs,
    input  logic                       voiced,
    input  logic [15:0]                freq_count,
    input  logic                       frame_strobe,
    output logic [ADDR_W-1:0]          ddr_addr,
    output logic                       ddr_write,
    output logic [DATA_W-1:0]          ddr_writedata,
    input  logic                       ddr_waitrequest,
    input  logic [2:0]                 addr,
    input  logic                       read,
    input  logic                       write,
    input  logic [15:0]                writedata,
    output logic [15:0]                readdata
);

    localparam int FRAME_WORDS = NUM_COEF + 2;
    localparam int IDX_W       = $clog2(FRAME_WORDS);

    state_t             state_q, state_d;
    logic [15:0]        base_addr, num_frames, step;
    logic [15:0]        frame_cnt, drop_count;
    logic [ADDR_W-1:0]  addr_ptr;
    logic [IDX_W-1:0]   word_idx;
    logic [DATA_W-1:0]  buf_word;
    logic [15:0]        csr_rdata;

    logic start, soft_rst, xfer, last_word;
    logic init, load_in, promote, capture_req;
    logic shadow_full, overrun;

    assign start     = write && (addr == CSR_START) && writedata[0];
    assign soft_rst  = write && (addr == CSR_SRST) && writedata[0];
    assign xfer      = (state_q == WRITE) && !ddr_waitrequest;
    assign last_word = xfer && (word_idx == IDX_W'(FRAME_WORDS - 1));

    always_comb begin
        state_d     = state_q;
        init        = 1'b0;
        load_in     = 1'b0;
        promote     = 1'b0;
        capture_req = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    init    = 1'b1;
                    state_d = (num_frames == 16'd0) ? DONE : ARMED;
                end
            end
            ARMED: begin
                if (shadow_full) begin
                    promote     = 1'b1;
                    capture_req = frame_strobe;
                    state_d     = WRITE;
                end else if (frame_strobe) begin
                    load_in = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                capture_req = frame_strobe;
                if (last_word) begin
                    if (frame_cnt + 16'd1 == num_frames) begin
                        capture_req = 1'b0;
                        state_d     = DONE;
                    end else if (shadow_full) begin
                        promote = 1'b1;
                    end else begin
                        // A frame arriving right now lands in the shadow and is picked up from ARMED.
                        state_d = ARMED;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (soft_rst) begin
            state_d     = IDLE;
            init        = 1'b0;
            load_in     = 1'b0;
            promote     = 1'b0;
            capture_req = 1'b0;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (addr)
            CSR_BASE:    csr_rdata = base_addr;
            CSR_NFRAMES: csr_rdata = num_frames;
            CSR_STEP:    csr_rdata = step;
            CSR_DONE:    csr_rdata = {15'b0, state_q == DONE};
            CSR_DROP:    csr_rdata = drop_count;
            default:     csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            base_addr  <= '0;
            num_frames <= '0;
            step       <= '0;
            addr_ptr   <= '0;
            word_idx   <= '0;
            frame_cnt  <= '0;
            drop_count <= '0;
            readdata   <= '0;
        end else begin
            if (write && addr == CSR_BASE)    base_addr  <= writedata;
            if (write && addr == CSR_NFRAMES) num_frames <= writedata;
            if (write && addr == CSR_STEP)    step       <= writedata;
            if (read)                         readdata   <= csr_rdata;
            state_q <= state_d;
            if (soft_rst) begin
                addr_ptr   <= '0;
                word_idx   <= '0;
                frame_cnt  <= '0;
                drop_count <= '0;
            end else begin
                if (init) begin
                    frame_cnt  <= '0;
                    drop_count <= '0;
                    addr_ptr   <= ADDR_W'(base_addr);
                    word_idx   <= '0;
                end
                if (xfer) begin
                    addr_ptr <= addr_ptr + ADDR_W'(step);
                    word_idx <= last_word ? '0 : word_idx + IDX_W'(1);
                end
                if (last_word) frame_cnt <= frame_cnt + 16'd1;
                if (overrun && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    lpc_frame_buf #(
        .NUM_COEF (NUM_COEF),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .clear       (soft_rst | init),
        .coefs       (coefs),
        .voiced      (voiced),
        .freq_count  (DATA_W'(freq_count)),
        .load_in     (load_in),
        .promote     (promote),
        .capture_req (capture_req),
        .word_idx    (word_idx),
        .word        (buf_word),
        .shadow_full (shadow_full),
        .overrun     (overrun)
    );

    assign ddr_write     = (state_q == WRITE);
    assign ddr_addr      = ddr_write ? addr_ptr : '0;
    assign ddr_writedata = ddr_write ? buf_word : '0;

endmodule

// File: tb/tb_lpc_frame_writer.sv
// Directed bench for lpc_frame_writer: DDR writes are logged at the accepting edge and compared with hand-built frames.
module tb_lpc_frame_writer;

    localparam int NC = 11;
    localparam int DW = 16;
    localparam int AW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NC*DW-1:0] coefs = '0;
    logic            voiced = 1'b0;
    logic [15:0]     freq_count = '0;
    logic            frame_strobe = 1'b0;
    logic [AW-1:0]   ddr_addr;
    logic            ddr_write;
    logic [DW-1:0]   ddr_writedata;
    logic            ddr_waitrequest = 1'b0;
    logic [2:0]      addr = '0;
    logic            read = 1'b0;
    logic            write = 1'b0;
    logic [15:0]     writedata = '0;
    logic [15:0]     readdata;

    lpc_frame_writer dut (
        .clk             (clk),
        .rst             (rst),
        .coefs           (coefs),
        .voiced          (voiced),
        .freq_count      (freq_count),
        .frame_strobe    (frame_strobe),
        .ddr_addr        (ddr_addr),
        .ddr_write       (ddr_write),
        .ddr_writedata   (ddr_writedata),
        .ddr_waitrequest (ddr_waitrequest),
        .addr            (addr),
        .read            (read),
        .write           (write),
        .writedata       (writedata),
        .readdata        (readdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [15:0] log_addr [$];
    logic [15:0] log_data [$];
    int          log_cyc  [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ddr_write && !ddr_waitrequest) begin
            log_addr.push_back(ddr_addr);
            log_data.push_back(ddr_writedata);
            log_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] exp_word(input int b, input logic v, input logic [15:0] fc, input int idx);
        if (idx < NC)       return 16'(b + idx + 1);
        else if (idx == NC) return {15'b0, v};
        else                return fc;
    endfunction

    task automatic csr_wr(input logic [2:0] a, input logic [15:0] d);
        addr = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [15:0] d);
        addr = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic send(input int b, input logic v, input logic [15:0] fc);
        for (int i = 0; i < NC; i++) coefs[i*DW +: DW] = 16'(b + i + 1);
        voiced = v; freq_count = fc; frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int k = 0; k < budget && log_addr.size() < n; k++) @(negedge clk);
    endtask

    task automatic clear_log;
        log_addr.delete(); log_data.delete(); log_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int bad;
        bit found;

        repeat (3) @(negedge clk);
        check("rst_ddr_write", ddr_write, 0);
        check("rst_ddr_addr", ddr_addr, 0);
        check("rst_ddr_wdata", ddr_writedata, 0);
        check("rst_readdata", readdata, 0);
        rst = 1'b1;
        @(negedge clk);
        csr_rd(3'd0, d); check("rst_base", d, 0);
        csr_rd(3'd5, d); check("rst_done", d, 0);

        // single frame, no stalls
        csr_wr(3'd0, 16'h0100); csr_wr(3'd2, 16'd1); csr_wr(3'd1, 16'd1); csr_wr(3'd4, 16'd1);
        send(0, 1'b1, 16'd57);
        wait_writes(13, 60);
        repeat (20) @(negedge clk);
        check("t1_nwrites", log_addr.size(), 13);
        for (int i = 0; i < 13 && i < log_addr.size(); i++) begin
            check($sformatf("t1_addr%0d", i), log_addr[i], 16'h0100 + 16'(i));
            check($sformatf("t1_data%0d", i), log_data[i], exp_word(0, 1'b1, 16'd57, i));
        end
        csr_rd(3'd5, d); check("t1_done", d, 1);

        // waitrequest held on word 4
        clear_log();
        csr_wr(3'd4, 16'd1);
        send(0, 1'b1, 16'd57);
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (ddr_write && ddr_addr == 16'h0104) begin found = 1; break; end
            @(negedge clk);
        end
        check("t2_found_word4", found, 1);
        ddr_waitrequest = 1'b1;
        for (int s = 0; s < 4; s++) begin
            if (s == 3) ddr_waitrequest = 1'b0;
            check($sformatf("t2_hold_addr%0d", s), ddr_addr, 16'h0104);
            check($sformatf("t2_hold_data%0d", s), ddr_writedata, 16'd5);
            @(negedge clk);
        end
        ddr_waitrequest = 1'b0;
        wait_writes(13, 60);
        repeat (5) @(negedge clk);
        check("t2_nwrites", log_addr.size(), 13);
        bad = 0;
        for (int i = 0; i < log_addr.size(); i++)
            if (log_addr[i] != 16'h0100 + 16'(i) || log_data[i] != exp_word(0, 1'b1, 16'd57, i)) bad++;
        check("t2_image_bad", bad, 0);
        if (log_cyc.size() >= 5) check("t2_stall_gap", log_cyc[4] - log_cyc[3], 4);

        // three frames, step 2, address wrap
        clear_log();
        csr_wr(3'd0, 16'hFFF8); csr_wr(3'd2, 16'd2); csr_wr(3'd1, 16'd3); csr_wr(3'd4, 16'd1);
        for (int f = 0; f < 3; f++) begin
            send(f * 'h100 + 'h20, 1'(f), 16'(100 + f));
            repeat (299) @(negedge clk);
        end
        wait_writes(39, 50);
        repeat (5) @(negedge clk);
        check("t3_nwrites", log_addr.size(), 39);
        if (log_addr.size() >= 5) begin
            check("t3_addr3", log_addr[3], 16'hFFFE);
            check("t3_addr4_wrap", log_addr[4], 16'h0000);
        end
        bad = 0;
        for (int n = 0; n < log_addr.size(); n++)
            if (log_addr[n] != 16'(32'hFFF8 + 2 * n) ||
                log_data[n] != exp_word((n / 13) * 'h100 + 'h20, 1'(n / 13), 16'(100 + n / 13), n % 13)) bad++;
        check("t3_image_bad", bad, 0);
        csr_rd(3'd5, d); check("t3_done", d, 1);

        // overrun: two frames back-to-back, third dropped
        clear_log();
        csr_wr(3'd0, 16'h0200); csr_wr(3'd2, 16'd1); csr_wr(3'd1, 16'd4); csr_wr(3'd4, 16'd1);
        send('h300, 1'b0, 16'd10);
        @(negedge clk);
        send('h400, 1'b1, 16'd20);
        @(negedge clk);
        send('h500, 1'b0, 16'd30);
        wait_writes(26, 80);
        repeat (10) @(negedge clk);
        check("t4_nwrites", log_addr.size(), 26);
        bad = 0;
        for (int n = 0; n < log_addr.size(); n++)
            if (log_addr[n] != 16'h0200 + 16'(n) ||
                log_data[n] != (n < 13 ? exp_word('h300, 1'b0, 16'd10, n) : exp_word('h400, 1'b1, 16'd20, n - 13))) bad++;
        check("t4_image_bad", bad, 0);
        if (log_cyc.size() == 26) check("t4_no_gap", log_cyc[25] - log_cyc[0], 25);
        csr_rd(3'd7, d); check("t4_drop_count", d, 1);
        csr_rd(3'd5, d); check("t4_not_done", d, 0);

        // hard reset in the middle of a frame
        rst = 1'b0; repeat (2) @(negedge clk); rst = 1'b1;
        csr_wr(3'd0, 16'h0300); csr_wr(3'd2, 16'd1); csr_wr(3'd1, 16'd2);
        csr_rd(3'd0, d); check("t5_base_rb", d, 16'h0300);
        csr_wr(3'd4, 16'd1);
        clear_log();
        send('h600, 1'b1, 16'd5);
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (ddr_write && ddr_addr == 16'h0306) begin found = 1; break; end
            @(negedge clk);
        end
        check("t5_found_word6", found, 1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ddr_write_off", ddr_write, 0);
        check("t5_readdata_clr", readdata, 0);
        rst = 1'b1;
        check("t5_nwrites", log_addr.size(), 7);
        if (log_addr.size() >= 1) check("t5_last_addr", log_addr[log_addr.size() - 1], 16'h0306);
        csr_rd(3'd0, d); check("t5_base_clr", d, 0);
        csr_rd(3'd1, d); check("t5_nframes_clr", d, 0);
        csr_rd(3'd2, d); check("t5_step_clr", d, 0);
        clear_log();
        send('h700, 1'b0, 16'd1);
        repeat (30) @(negedge clk);
        check("t5_idle_strobe_writes", log_addr.size(), 0);
        csr_rd(3'd7, d); check("t5_idle_no_drop", d, 0);

        // zero frames, then soft reset
        csr_wr(3'd0, 16'h0123); csr_wr(3'd1, 16'd0); csr_wr(3'd4, 16'd1);
        csr_rd(3'd5, d); check("t6_done_zero", d, 1);
        check("t6_no_writes", log_addr.size(), 0);
        csr_wr(3'd6, 16'd1);
        csr_rd(3'd5, d); check("t6_srst_done", d, 0);
        csr_rd(3'd0, d); check("t6_srst_base_kept", d, 16'h0123);
        csr_rd(3'd3, d); check("t6_addr3_zero", d, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
